// File: rtl/mem_resp_if.sv
// Request/response handshake bundle between an initiator (master) and the
// memory responder (slave).
interface mem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_resp.sv
// Single-outstanding RV32I load/store responder: word RAM, 64-bit cycle
// counter and an LED register, with a fixed LATENCY-cycle response delay.
module mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  mem_resp_if.slave   bus,
  output logic [31:0] led
);
  localparam int              AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0]     RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam int              WCW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0]  WLOAD     = (LATENCY > 0) ? WCW'(LATENCY - 1) : '0;
  localparam logic [31:0]     A_CLO     = 32'h1000_0000;
  localparam logic [31:0]     A_CHI     = 32'h1000_0004;
  localparam logic [31:0]     A_LED     = 32'h1000_0008;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state, w_next;
  logic [WCW-1:0]  r_wcnt;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [31:0]     r_addr, r_wdata;
  logic [63:0]     r_cnt;
  logic [31:0]     r_led, r_rdata;
  logic            r_err;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            w_accept, w_enter;
  logic            w_we;
  logic [2:0]      w_f3;
  logic [31:0]     w_addr, w_wdata;
  logic            w_is_ram, w_is_clo, w_is_chi, w_is_led, w_err;
  logic [AW-1:0]   w_widx;
  logic [31:0]     w_word, w_sh, w_load, w_wsh;
  logic [3:0]      w_bmask;

  assign w_accept = bus.req_valid && (r_state == IDLE);
  // With LATENCY=0 the access executes on the accept edge itself, so the
  // live request fields are used instead of the (not yet latched) copies.
  assign w_enter  = ((r_state == WAIT) && (r_wcnt == '0)) || ((LATENCY == 0) && w_accept);
  assign w_we     = (r_state == IDLE) ? bus.req_we     : r_we;
  assign w_f3     = (r_state == IDLE) ? bus.req_funct3 : r_f3;
  assign w_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_wdata  = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign led            = r_led;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (r_wcnt == '0) w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Address decode and fault classification
  always_comb begin
    w_is_ram = (w_addr < RAM_BYTES);
    w_is_clo = (w_addr == A_CLO);
    w_is_chi = (w_addr == A_CHI);
    w_is_led = (w_addr == A_LED);
    w_widx   = w_addr[AW+1:2];
    w_err    = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11)
            || ((w_f3[1:0] == 2'b01) && w_addr[0])
            || ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00))
            || !(w_is_ram || w_is_clo || w_is_chi || w_is_led)
            || (w_we && (w_f3[2] || w_is_clo || w_is_chi));
  end

  always_comb begin
    w_word = '0;
    if (w_is_ram)      w_word = mem[w_widx];
    else if (w_is_clo) w_word = r_cnt[31:0];
    else if (w_is_chi) w_word = r_cnt[63:32];
    else if (w_is_led) w_word = r_led;
    w_sh = w_word >> {w_addr[1:0], 3'b000};
    case (w_f3)
      3'b000:  w_load = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_load = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_load = w_sh;
      3'b100:  w_load = {24'h0, w_sh[7:0]};
      3'b101:  w_load = {16'h0, w_sh[15:0]};
      default: w_load = '0;
    endcase
    w_wsh = w_wdata << {w_addr[1:0], 3'b000};
    case (w_f3)
      3'b000:  w_bmask = 4'b0001 << w_addr[1:0];
      3'b001:  w_bmask = 4'b0011 << w_addr[1:0];
      3'b010:  w_bmask = 4'b1111;
      default: w_bmask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_led   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 64'd1;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_funct3;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_wcnt  <= WLOAD;
      end else if ((r_state == WAIT) && (r_wcnt != '0)) begin
        r_wcnt <= r_wcnt - WCW'(1);
      end
      if (w_enter) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_we) ? 32'h0 : w_load;
        if (!w_err && w_we && w_is_led)
          for (int b = 0; b < 4; b++)
            if (w_bmask[b]) r_led[8*b +: 8] <= w_wsh[8*b +: 8];
      end
    end
  end

  // RAM is deliberately outside the reset domain; a reset on the commit edge
  // still suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_enter && !w_err && w_we && w_is_ram)
      for (int b = 0; b < 4; b++)
        if (w_bmask[b]) mem[w_widx][8*b +: 8] <= w_wsh[8*b +: 8];
  end
endmodule

// File: tb/tb_mem_resp.sv
// Directed-vector bench for mem_resp (LATENCY=1): table of load/store
// transactions plus hand sequences for handshake timing and reset aborts.
module tb_mem_resp;
  logic        clk;
  logic        rst;
  logic [31:0] led;
  int          checks = 0;
  int          errors = 0;

  mem_resp_if bus ();

  mem_resp #(.DEPTH_WORDS(256), .LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vt [40];
  int   nv = 0;

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vt[nv].we = we; vt[nv].f3 = f3; vt[nv].addr = a;
    vt[nv].wd = wd; vt[nv].rd = rd; vt[nv].er = er;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge, DUT idle again.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) begin
      checks++; errors++;
      $display("FAIL xact_timeout: no resp_valid for addr %h", a);
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, c1, c2;
    logic        er;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst.resp_err",   {31'b0, bus.resp_err},   32'd0);
    chk("rst.led",        led,                     32'd0);

    //   we  f3      addr           wdata          exp rdata      err
    add(1, 3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    add(0, 3'b000, 32'h0000_0003, 32'h0,         32'hFFFF_FFDE, 0);
    add(0, 3'b100, 32'h0000_0003, 32'h0,         32'h0000_00DE, 0);
    add(0, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_BEEF, 0);
    add(0, 3'b001, 32'h0000_0002, 32'h0,         32'hFFFF_DEAD, 0);
    add(1, 3'b000, 32'h0000_0001, 32'h0000_0012, 32'h0000_0000, 0);
    add(0, 3'b010, 32'h0000_0000, 32'h0,         32'hDEAD_12EF, 0);
    add(0, 3'b010, 32'h0000_0002, 32'h0,         32'h0000_0000, 1);
    add(1, 3'b001, 32'h0000_0001, 32'h0000_AAAA, 32'h0000_0000, 1);
    add(0, 3'b011, 32'h0000_0000, 32'h0,         32'h0000_0000, 1);
    add(1, 3'b010, 32'h1000_0000, 32'h0000_0001, 32'h0000_0000, 1);
    add(0, 3'b010, 32'h2000_0000, 32'h0,         32'h0000_0000, 1);
    add(0, 3'b010, 32'h0000_0000, 32'h0,         32'hDEAD_12EF, 0);
    add(1, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 0);
    add(1, 3'b001, 32'h0000_0006, 32'h1234_8765, 32'h0000_0000, 0);
    add(0, 3'b010, 32'h0000_0004, 32'h0,         32'h8765_0000, 0);
    add(0, 3'b001, 32'h0000_0006, 32'h0,         32'hFFFF_8765, 0);
    add(0, 3'b101, 32'h0000_0006, 32'h0,         32'h0000_8765, 0);
    add(1, 3'b100, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add(1, 3'b101, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    add(0, 3'b010, 32'h0000_0004, 32'h0,         32'h8765_0000, 0);
    add(0, 3'b101, 32'h0000_0001, 32'h0,         32'h0000_0000, 1);
    add(0, 3'b110, 32'h0000_0000, 32'h0,         32'h0000_0000, 1);
    add(0, 3'b111, 32'h0000_0000, 32'h0,         32'h0000_0000, 1);
    add(1, 3'b010, 32'h1000_0008, 32'hA5A5_0F0F, 32'h0000_0000, 0);
    add(0, 3'b010, 32'h1000_0008, 32'h0,         32'hA5A5_0F0F, 0);
    add(0, 3'b000, 32'h1000_0008, 32'h0,         32'h0000_000F, 0);
    add(0, 3'b000, 32'h1000_0009, 32'h0,         32'h0000_0000, 1);
    add(1, 3'b010, 32'h1000_0004, 32'h0000_0001, 32'h0000_0000, 1);
    add(0, 3'b010, 32'h1000_0004, 32'h0,         32'h0000_0000, 0);
    add(1, 3'b010, 32'h0000_03FC, 32'h0102_0304, 32'h0000_0000, 0);
    add(0, 3'b000, 32'h0000_03FF, 32'h0,         32'h0000_0001, 0);
    add(0, 3'b001, 32'h0000_03FE, 32'h0,         32'h0000_0102, 0);
    add(0, 3'b010, 32'h0000_0400, 32'h0,         32'h0000_0000, 1);
    add(1, 3'b010, 32'h0000_0008, 32'h0000_0077, 32'h0000_0000, 0);

    for (int i = 0; i < nv; i++) begin
      xact(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wd, rd, er);
      chk($sformatf("vec%0d.rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d.err", i), {31'b0, er}, {31'b0, vt[i].er});
    end
    chk("led.port", led, 32'hA5A5_0F0F);

    // Latency, response hold under back-pressure, ignored requests outside IDLE
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0;
    @(negedge clk);
    chk("hold.wait_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("hold.wait_ready", {31'b0, bus.req_ready},  32'd0);
    bus.req_we = 1'b1; bus.req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("hold.first_valid", {31'b0, bus.resp_valid}, 32'd1);
    chk("hold.first_rdata", bus.resp_rdata, 32'hDEAD_12EF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.valid", c), {31'b0, bus.resp_valid}, 32'd1);
      chk($sformatf("hold%0d.rdata", c), bus.resp_rdata, 32'hDEAD_12EF);
      chk($sformatf("hold%0d.ready", c), {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("hold.after_ready", {31'b0, bus.req_ready},  32'd1);
    chk("hold.after_valid", {31'b0, bus.resp_valid}, 32'd0);
    xact(1'b0, 3'b010, 32'h0, 32'h0, rd, er);
    chk("hold.ram_intact", rd, 32'hDEAD_12EF);

    // Reset while the store waits: store must not commit
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h8; bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("abort.ready", {31'b0, bus.req_ready},  32'd1);
    chk("abort.led",   led, 32'd0);
    // Counter is 0 after the reset edge, 1 when sampled two edges later
    xact(1'b0, 3'b010, 32'h1000_0000, 32'h0, rd, er);
    chk("cnt.after_rst", rd, 32'd1);
    xact(1'b0, 3'b010, 32'h1000_0004, 32'h0, rd, er);
    chk("cnt.hi_after_rst", rd, 32'd0);
    xact(1'b0, 3'b010, 32'h0000_0008, 32'h0, rd, er);
    chk("abort.ram_old", rd, 32'h0000_0077);
    xact(1'b0, 3'b010, 32'h1000_0008, 32'h0, rd, er);
    chk("abort.led_read", rd, 32'd0);

    // Sample edges are 7 idle + handshake + accept + enter = 10 apart
    xact(1'b0, 3'b010, 32'h1000_0000, 32'h0, c1, er);
    repeat (7) @(negedge clk);
    xact(1'b0, 3'b010, 32'h1000_0000, 32'h0, c2, er);
    chk("cnt.delta", c2 - c1, 32'd10);

    // Reset while the response is presented drops it
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("drop.pre_valid", {31'b0, bus.resp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("drop.valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("drop.rdata", bus.resp_rdata, 32'd0);
    chk("drop.err",   {31'b0, bus.resp_err}, 32'd0);
    chk("drop.ready", {31'b0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
